// File: rtl/ecc_mult_arbiter.sv
// Round-robin sequencer sharing one modular multiplier among NREQ requesters; grant 1 cycle after request,
// done 1 cycle after the multiplier's ready edge. Requesters hold i_req until granted; a watchdog aborts stuck operations.
module ecc_mult_arbiter #(
    parameter int NREQ    = 4,
    parameter int W       = 256,
    parameter int TIMEOUT = 1024
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [W-1:0]      i_p,
    input  logic [NREQ-1:0]   i_req,
    input  logic [NREQ*W-1:0] i_a,
    input  logic [NREQ*W-1:0] i_b,
    output logic [NREQ-1:0]   o_gnt,
    output logic [NREQ-1:0]   o_done,
    output logic [W-1:0]      o_result,
    output logic              o_err,
    output logic              o_busy,
    output logic              o_mul_start,
    output logic [W-1:0]      o_mul_a,
    output logic [W-1:0]      o_mul_b,
    output logic [W-1:0]      o_mul_m,
    input  logic [W-1:0]      i_mul_p,
    input  logic              i_mul_ready
);
    localparam int IW = $clog2(NREQ);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   ptr, ptr_nxt, owner, owner_nxt, sel_idx;
    logic [TW-1:0]   timer, timer_nxt;
    logic            rdy_d, rdy_rise, timeout_hit, sel_vld;
    logic [NREQ-1:0] gnt_nxt, done_nxt;
    logic [W-1:0]    result_nxt, mul_a_nxt, mul_b_nxt, mul_m_nxt;
    logic            err_nxt, start_nxt;

    // A ready level left over from the previous operation must not count as completion.
    assign rdy_rise    = i_mul_ready & ~rdy_d;
    assign timeout_hit = (timer == TW'(TIMEOUT - 1));

    always_comb begin
        int j;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!sel_vld && i_req[j]) begin
                sel_vld = 1'b1;
                sel_idx = IW'(j);
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        owner_nxt  = owner;
        timer_nxt  = timer;
        gnt_nxt    = '0;
        done_nxt   = '0;
        result_nxt = '0;
        err_nxt    = 1'b0;
        start_nxt  = 1'b0;
        mul_a_nxt  = o_mul_a;
        mul_b_nxt  = o_mul_b;
        mul_m_nxt  = o_mul_m;
        case (state)
            S_IDLE: begin
                if (sel_vld) begin
                    mul_a_nxt = i_a[int'(sel_idx)*W +: W];
                    mul_b_nxt = i_b[int'(sel_idx)*W +: W];
                    mul_m_nxt = i_p;
                    owner_nxt = sel_idx;
                    gnt_nxt   = NREQ'(1) << sel_idx;
                    start_nxt = 1'b1;
                    timer_nxt = '0;
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (rdy_rise) begin
                    result_nxt = i_mul_p;
                    done_nxt   = NREQ'(1) << owner;
                    state_nxt  = S_DONE;
                end else if (timeout_hit) begin
                    err_nxt   = 1'b1;
                    done_nxt  = NREQ'(1) << owner;
                    state_nxt = S_DONE;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end
            S_DONE: begin
                ptr_nxt   = (owner == IW'(NREQ - 1)) ? '0 : owner + 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= S_IDLE;
            ptr         <= '0;
            owner       <= '0;
            timer       <= '0;
            rdy_d       <= 1'b1;
            o_gnt       <= '0;
            o_done      <= '0;
            o_result    <= '0;
            o_err       <= 1'b0;
            o_busy      <= 1'b0;
            o_mul_start <= 1'b0;
            o_mul_a     <= '0;
            o_mul_b     <= '0;
            o_mul_m     <= '0;
        end else begin
            state       <= state_nxt;
            ptr         <= ptr_nxt;
            owner       <= owner_nxt;
            timer       <= timer_nxt;
            rdy_d       <= i_mul_ready;
            o_gnt       <= gnt_nxt;
            o_done      <= done_nxt;
            o_result    <= result_nxt;
            o_err       <= err_nxt;
            o_busy      <= (state_nxt != S_IDLE);
            o_mul_start <= start_nxt;
            o_mul_a     <= mul_a_nxt;
            o_mul_b     <= mul_b_nxt;
            o_mul_m     <= mul_m_nxt;
        end
    end
endmodule

// File: tb/tb_ecc_mult_arbiter.sv
// Bench for ecc_mult_arbiter with a behavioural multiplier (10 busy cycles, ready held until next start).
`timescale 1ns/1ps
module tb_ecc_mult_arbiter;
    localparam int NREQ = 4, W = 16, TIMEOUT = 16, L = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [W-1:0]      p = '0;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] a = '0, b = '0;
    logic [NREQ-1:0]   gnt, done;
    logic [W-1:0]      result, mul_a, mul_b, mul_m;
    logic              err, busy, mul_start;
    logic [W-1:0]      mul_p = '0;
    logic              mul_rdy = 1'b1;
    logic              m_busy = 1'b0, stuck = 1'b0;
    int                m_cnt = 0;

    typedef struct packed {
        logic [NREQ-1:0] done;
        logic [W-1:0]    res;
        logic            err;
    } exp_t;
    exp_t sb[$];
    exp_t e;
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    ecc_mult_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_p(p), .i_req(req), .i_a(a), .i_b(b),
        .o_gnt(gnt), .o_done(done), .o_result(result), .o_err(err), .o_busy(busy),
        .o_mul_start(mul_start), .o_mul_a(mul_a), .o_mul_b(mul_b), .o_mul_m(mul_m),
        .i_mul_p(mul_p), .i_mul_ready(mul_rdy)
    );

    // Behavioural multiplier: ready drops after start, rises after L busy cycles unless stuck.
    always @(posedge clk) begin
        if (!rst_n) begin
            mul_rdy <= 1'b1;
            m_busy  <= 1'b0;
            m_cnt   <= 0;
            mul_p   <= '0;
        end else if (mul_start) begin
            mul_rdy <= 1'b0;
            m_busy  <= 1'b1;
            m_cnt   <= 0;
            mul_p   <= W'((32'(mul_a) * 32'(mul_b)) % 32'(mul_m));
        end else if (m_busy) begin
            if (m_cnt == L - 1) begin
                m_busy <= 1'b0;
                if (!stuck) mul_rdy <= 1'b1;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            total++;
            if (!$onehot0(gnt) || !$onehot0(done)) begin
                bad++;
                $display("FAIL onehot: gnt=%b done=%b required at most one bit each", gnt, done);
            end
        end
    end

    task automatic set_op(input int k, input int av, input int bv);
        a[k*W +: W] = W'(av);
        b[k*W +: W] = W'(bv);
    endtask

    task automatic push_exp(input logic [NREQ-1:0] d, input int r, input logic er);
        exp_t x;
        x.done = d;
        x.res  = W'(r);
        x.err  = er;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        stuck = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_gnt(output int cyc);
        cyc = 0;
        while (gnt == '0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        if (gnt == '0) cyc = -1;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (done == '0 && cyc < 200);
        if (done == '0) cyc = -1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(negedge clk);
        total++;
        if ({gnt, done, err, busy, mul_start, result, mul_a, mul_b, mul_m} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: gnt=%b done=%b err=%b busy=%b start=%b res=%0d a=%0d b=%0d m=%0d required all 0",
                     gnt, done, err, busy, mul_start, result, mul_a, mul_b, mul_m);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || gnt !== '0) begin
            bad++;
            $display("FAIL idle_no_req: busy=%b gnt=%b required 0", busy, gnt);
        end
    endtask

    task automatic test_single();
        int c;
        do_reset();
        p = 97;
        set_op(1, 5, 7);
        req = 4'b0010;
        push_exp(4'b0010, 35, 1'b0);
        wait_gnt(c);
        total++;
        if (gnt !== 4'b0010 || mul_start !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_gnt: gnt=%b start=%b busy=%b required 0010 1 1", gnt, mul_start, busy);
        end
        total++;
        if (mul_a !== 16'd5 || mul_b !== 16'd7 || mul_m !== 16'd97) begin
            bad++;
            $display("FAIL single_latch: a=%0d b=%0d m=%0d required 5 7 97", mul_a, mul_b, mul_m);
        end
        req = '0;
        @(negedge clk);
        total++;
        if (gnt !== '0 || mul_start !== 1'b0) begin
            bad++;
            $display("FAIL single_pulse: gnt=%b start=%b required 0 0", gnt, mul_start);
        end
        wait_done(c);
        total++;
        if (c + 1 != 12) begin
            bad++;
            $display("FAIL single_latency: got %0d cycles required 12", c + 1);
        end
        e = sb.pop_front();
        total++;
        if (done !== e.done || result !== e.res || err !== e.err || busy !== 1'b1) begin
            bad++;
            $display("FAIL single_done: done=%b res=%0d err=%b busy=%b required %b %0d %b 1",
                     done, result, err, busy, e.done, e.res, e.err);
        end
        @(negedge clk);
        total++;
        if (done !== '0 || result !== '0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_clear: done=%b res=%0d busy=%b required 0 0 0", done, result, busy);
        end
    endtask

    task automatic test_back_to_back();
        int c;
        do_reset();
        p = 97;
        set_op(0, 4, 6);
        req = 4'b0001;
        push_exp(4'b0001, 24, 1'b0);
        wait_gnt(c);
        req = '0;
        wait_done(c);
        e = sb.pop_front();
        total++;
        if (done !== e.done || result !== e.res || err !== e.err) begin
            bad++;
            $display("FAIL b2b_first: done=%b res=%0d err=%b required %b %0d %b", done, result, err, e.done, e.res, e.err);
        end
        set_op(2, 11, 9);
        req = 4'b0100;
        push_exp(4'b0100, 2, 1'b0);
        wait_gnt(c);
        total++;
        if (c != 2 || gnt !== 4'b0100) begin
            bad++;
            $display("FAIL b2b_regrant: got %0d cycles gnt=%b required 2 0100", c, gnt);
        end
        req = '0;
        wait_done(c);
        total++;
        if (c != 12) begin
            bad++;
            $display("FAIL stale_ready_latency: got %0d cycles required 12", c);
        end
        e = sb.pop_front();
        total++;
        if (done !== e.done || result !== e.res || err !== e.err) begin
            bad++;
            $display("FAIL stale_ready_done: done=%b res=%0d err=%b required %b %0d %b", done, result, err, e.done, e.res, e.err);
        end
    endtask

    task automatic test_round_robin();
        int c;
        logic [NREQ-1:0] want;
        do_reset();
        p = 97;
        for (int k = 0; k < NREQ; k++) set_op(k, k + 2, 3);
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            want = NREQ'(1) << (g % NREQ);
            wait_gnt(c);
            total++;
            if (gnt !== want) begin
                bad++;
                $display("FAIL rr_gnt%0d: gnt=%b required %b", g, gnt, want);
            end
            push_exp(want, ((g % NREQ) + 2) * 3, 1'b0);
            if (g == 4) req = '0;
            wait_done(c);
            e = sb.pop_front();
            total++;
            if (done !== e.done || result !== e.res || err !== e.err) begin
                bad++;
                $display("FAIL rr_done%0d: done=%b res=%0d err=%b required %b %0d %b",
                         g, done, result, err, e.done, e.res, e.err);
            end
        end
    endtask

    task automatic test_timeout();
        int c;
        do_reset();
        p = 97;
        stuck = 1'b1;
        set_op(2, 3, 4);
        req = 4'b0100;
        push_exp(4'b0100, 0, 1'b1);
        wait_gnt(c);
        req = '0;
        wait_done(c);
        total++;
        if (c != TIMEOUT) begin
            bad++;
            $display("FAIL timeout_latency: got %0d cycles required %0d", c, TIMEOUT);
        end
        e = sb.pop_front();
        total++;
        if (done !== e.done || result !== e.res || err !== e.err) begin
            bad++;
            $display("FAIL timeout_done: done=%b res=%0d err=%b required %b %0d %b", done, result, err, e.done, e.res, e.err);
        end
        stuck = 1'b0;
        set_op(0, 2, 5);
        set_op(3, 6, 7);
        req = 4'b1001;
        wait_gnt(c);
        total++;
        if (gnt !== 4'b1000) begin
            bad++;
            $display("FAIL timeout_next_gnt: gnt=%b required 1000", gnt);
        end
        push_exp(4'b1000, 42, 1'b0);
        req = '0;
        wait_done(c);
        e = sb.pop_front();
        total++;
        if (done !== e.done || result !== e.res || err !== e.err) begin
            bad++;
            $display("FAIL timeout_next_done: done=%b res=%0d err=%b required %b %0d %b", done, result, err, e.done, e.res, e.err);
        end
    endtask

    task automatic test_reset_mid_wait();
        int c;
        do_reset();
        p = 97;
        set_op(1, 8, 8);
        req = 4'b0010;
        wait_gnt(c);
        set_op(0, 10, 10);
        set_op(3, 2, 2);
        rst_n = 1'b0;
        req = 4'b1001;
        @(negedge clk);
        total++;
        if ({gnt, done, err, busy, mul_start, result, mul_a, mul_b, mul_m} !== '0) begin
            bad++;
            $display("FAIL midwait_reset: gnt=%b done=%b err=%b busy=%b start=%b res=%0d a=%0d required all 0",
                     gnt, done, err, busy, mul_start, result, mul_a);
        end
        rst_n = 1'b1;
        wait_gnt(c);
        total++;
        if (c != 1 || gnt !== 4'b0001) begin
            bad++;
            $display("FAIL midwait_regrant: got %0d cycles gnt=%b required 1 0001", c, gnt);
        end
        push_exp(4'b0001, 3, 1'b0);
        req = '0;
        wait_done(c);
        e = sb.pop_front();
        total++;
        if (c != 12 || done !== e.done || result !== e.res || err !== e.err) begin
            bad++;
            $display("FAIL midwait_done: cyc=%0d done=%b res=%0d err=%b required 12 %b %0d %b",
                     c, done, result, err, e.done, e.res, e.err);
        end
    endtask

    task automatic test_withdrawn();
        int c;
        logic seen;
        do_reset();
        p = 97;
        set_op(0, 2, 2);
        set_op(2, 9, 9);
        req = 4'b0001;
        push_exp(4'b0001, 4, 1'b0);
        wait_gnt(c);
        req = '0;
        repeat (3) @(negedge clk);
        req = 4'b0100;
        @(negedge clk);
        req = '0;
        wait_done(c);
        e = sb.pop_front();
        total++;
        if (done !== e.done || result !== e.res || err !== e.err) begin
            bad++;
            $display("FAIL withdrawn_owner_done: done=%b res=%0d err=%b required %b %0d %b", done, result, err, e.done, e.res, e.err);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (gnt != '0 || done != '0) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL withdrawn_grant: activity=%b required 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_round_robin();
        test_timeout();
        test_reset_mid_wait();
        test_withdrawn();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
